key_event_arbiter: RTL and testbench

Debounces the board's active-low push-buttons, classifies each press as short or long, and arbitrates the per-key events onto one valid/ready event channel using round-robin. It sits between the raw `key_in` pins and any consumer of key events, such as LED mode control or menu logic. It replaces ad-hoc per-key edge detection with one queued, lossless-where-possible event source.

---
 rtl/key_pkg.sv | 14 +
 rtl/key_debounce.sv | 73 +++++++
 rtl/key_event_arbiter.sv | 131 +++++++++++++
 tb/tb_key_event_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and constants for the key event path.
package key_pkg;

    localparam logic EV_SHORT  = 1'b0;
    localparam logic EV_LONG   = 1'b1;
    localparam int   KEY_IDX_W = 3;

    // One key event: valid flag plus its type (EV_SHORT / EV_LONG).
    typedef struct packed {
        logic valid;
        logic is_long;
    } key_ev_t;

endpackage

// File: rtl/key_debounce.sv
// Per-key synchronizer, two-sample debounce, press timer and event pulse.
module key_debounce
    import key_pkg::*;
#(
    parameter int LONG_TICKS = 50
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    key_in,
    input  logic    tick,
    output logic    key_down,
    output key_ev_t ev
);

    localparam logic [7:0] LONG_T = 8'(LONG_TICKS);

    logic       s1, s2;
    logic       samp;
    logic       armed;
    logic       kd_d;
    logic       long_done;
    logic [7:0] timer;
    logic       press_edge;
    logic       long_fire;
    logic       short_fire;

    // Press/release qualification and single-cycle event pulses.
    always_comb begin
        press_edge = tick && (samp == s2) && s2 && !key_down && armed;
        long_fire  = !long_done && (timer == LONG_T);
        short_fire = kd_d && !key_down && (timer < LONG_T);
        ev.valid   = long_fire || short_fire;
        ev.is_long = long_fire ? EV_LONG : EV_SHORT;
    end

    // Synchronizer, debounce sampling, press timer and long-event latch.
    // A key must first be debounced as released (armed) before a press can
    // register, so a key held through reset is not taken as a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            samp      <= 1'b0;
            armed     <= 1'b0;
            key_down  <= 1'b0;
            kd_d      <= 1'b0;
            long_done <= 1'b0;
            timer     <= '0;
        end else begin
            s1   <= ~key_in;
            s2   <= s1;
            kd_d <= key_down;
            if (long_fire)
                long_done <= 1'b1;
            if (tick) begin
                samp <= s2;
                if (samp == s2) begin
                    if (!s2)
                        armed <= 1'b1;
                    if ((s2 != key_down) && (armed || !s2))
                        key_down <= s2;
                end
                if (press_edge) begin
                    timer     <= '0;
                    long_done <= 1'b0;
                end else if (key_down && (timer < LONG_T)) begin
                    timer <= timer + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/key_event_arbiter.sv
// Debounced key events, per-key pending slots, round-robin arbitration
// onto a single valid/ready event channel with sticky overflow flags.
module key_event_arbiter
    import key_pkg::*;
#(
    parameter int N_KEYS     = 4,
    parameter int SCAN_DIV   = 1_000_000,
    parameter int LONG_TICKS = 50
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_KEYS-1:0]    key_in,
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic [KEY_IDX_W-1:0] ev_key,
    output logic                 ev_long,
    output logic [N_KEYS-1:0]    key_down,
    output logic [N_KEYS-1:0]    ovf,
    input  logic                 ovf_clr
);

    localparam int CNT_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0]     cnt;
    logic                 tick;
    key_ev_t              ev [N_KEYS];
    logic [N_KEYS-1:0]    slot_v;
    logic [N_KEYS-1:0]    slot_l;
    logic [N_KEYS-1:0]    slot_clr;
    logic [N_KEYS-1:0]    ovf_set;
    logic [KEY_IDX_W-1:0] rr;
    logic [KEY_IDX_W-1:0] grant;
    logic                 gnt_long;
    logic                 any_pend;
    logic                 load;

    assign tick = (cnt == CNT_W'(SCAN_DIV - 1));

    // Scan tick divider shared by all keys.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        key_debounce #(
            .LONG_TICKS (LONG_TICKS)
        ) u_deb (
            .clk      (clk),
            .rst_n    (rst_n),
            .key_in   (key_in[k]),
            .tick     (tick),
            .key_down (key_down[k]),
            .ev       (ev[k])
        );
    end

    // Round-robin grant: first pending slot searching from rr upward.
    always_comb begin
        grant    = '0;
        gnt_long = 1'b0;
        any_pend = 1'b0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            int unsigned idx;
            idx = int'(rr) + i;
            if (idx >= N_KEYS)
                idx = idx - N_KEYS;
            if (!any_pend && slot_v[idx]) begin
                any_pend = 1'b1;
                grant    = KEY_IDX_W'(idx);
                gnt_long = slot_l[idx];
            end
        end
        load = any_pend && (!ev_valid || ev_ready);
    end

    // Slot drain and overflow detection; a slot being loaded this cycle
    // can take a new event without counting as an overflow.
    always_comb begin
        slot_clr = '0;
        ovf_set  = '0;
        for (int unsigned k = 0; k < N_KEYS; k++) begin
            slot_clr[k] = load && (grant == KEY_IDX_W'(k));
            ovf_set[k]  = ev[k].valid && slot_v[k] && !slot_clr[k];
        end
    end

    // Pending slots and sticky overflow flags (set beats clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_v <= '0;
            slot_l <= '0;
            ovf    <= '0;
        end else begin
            for (int unsigned k = 0; k < N_KEYS; k++) begin
                if (ev[k].valid) begin
                    slot_v[k] <= 1'b1;
                    slot_l[k] <= ev[k].is_long;
                end else if (slot_clr[k]) begin
                    slot_v[k] <= 1'b0;
                end
            end
            ovf <= (ovf & ~{N_KEYS{ovf_clr}}) | ovf_set;
        end
    end

    // Output register and round-robin pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_valid <= 1'b0;
            ev_key   <= '0;
            ev_long  <= 1'b0;
            rr       <= '0;
        end else if (load) begin
            ev_valid <= 1'b1;
            ev_key   <= grant;
            ev_long  <= gnt_long;
            if (int'(grant) == N_KEYS - 1)
                rr <= '0;
            else
                rr <= grant + KEY_IDX_W'(1);
        end else if (ev_ready) begin
            ev_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_key_event_arbiter.sv
// Scoreboard bench for key_event_arbiter: stimulus pushes expected events,
// a monitor pops and compares on every accepted transfer.
module tb_key_event_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_in;
    logic       ev_valid;
    logic       ev_ready;
    logic [2:0] ev_key;
    logic       ev_long;
    logic [3:0] key_down;
    logic [3:0] ovf;
    logic       ovf_clr;

    typedef struct {
        int key;
        int lng;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    key_event_arbiter #(
        .N_KEYS     (4),
        .SCAN_DIV   (4),
        .LONG_TICKS (5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (key_in),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_key   (ev_key),
        .ev_long  (ev_long),
        .key_down (key_down),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int key, input int lng);
        exp_t e;
        e.key = key;
        e.lng = lng;
        q.push_back(e);
    endtask

    task automatic wait_kd(input int k, input logic val, input string nm);
        int n = 0;
        while (key_down[k] !== val && n < 40) begin
            step();
            n++;
        end
        chk(nm, int'(key_down[k]), int'(val));
    endtask

    // Press is released 4 clk after the debounced rise: 3 timer ticks, short.
    task automatic press_short(input int k);
        key_in[k] = 1'b0;
        wait_kd(k, 1'b1, "press_rise");
        repeat (4) step();
        key_in[k] = 1'b1;
        wait_kd(k, 1'b0, "press_fall");
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (q.size() != 0 && n < 60) begin
            step();
            n++;
        end
        chk(nm, q.size(), 0);
    endtask

    // Monitor: every accepted transfer must match the head of the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && ev_valid && ev_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: got key=%0d long=%0d expected none", ev_key, ev_long);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("ev_key", int'(ev_key), e.key);
                    chk("ev_long", int'(ev_long), e.lng);
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        key_in   = 4'hF;
        ev_ready = 1'b1;
        ovf_clr  = 1'b0;
        repeat (3) step();
        chk("rst_ev_valid", int'(ev_valid), 0);
        chk("rst_ev_key", int'(ev_key), 0);
        chk("rst_ev_long", int'(ev_long), 0);
        chk("rst_key_down", int'(key_down), 0);
        chk("rst_ovf", int'(ovf), 0);
        rst_n = 1'b1;
        repeat (20) step();

        // Short press on key 2
        push(2, 0);
        key_in[2] = 1'b0;
        wait_kd(2, 1'b1, "short_kd_high");
        chk("short_not_early", q.size(), 1);
        repeat (4) step();
        key_in[2] = 1'b1;
        wait_kd(2, 1'b0, "short_kd_low");
        drain("short_drain");

        // Long press on key 1: event while held, nothing on release
        push(1, 1);
        key_in[1] = 1'b0;
        repeat (80) step();
        chk("long_while_held", q.size(), 0);
        chk("long_kd_held", int'(key_down[1]), 1);
        key_in[1] = 1'b1;
        wait_kd(1, 1'b0, "long_kd_low");
        repeat (20) step();

        // Glitch rejection on key 0 at several tick phases
        key_in[0] = 1'b0;
        step();
        key_in[0] = 1'b1;
        repeat (20) step();
        chk("glitch1_kd", int'(key_down[0]), 0);
        for (int off = 0; off < 4; off++) begin
            repeat (off) step();
            key_in[0] = 1'b0;
            repeat (3) step();
            key_in[0] = 1'b1;
            repeat (20) step();
            chk("glitch3_kd", int'(key_down[0]), 0);
        end

        // Round robin: key 0 short leaves rr=1, then keys 0 and 3 together
        push(0, 0);
        press_short(0);
        drain("rr_setup_drain");
        chk("rr_before", int'(dut.rr), 1);
        push(3, 0);
        push(0, 0);
        key_in = 4'b0110;
        wait_kd(3, 1'b1, "rr_kd3_high");
        chk("rr_kd0_high", int'(key_down[0]), 1);
        repeat (4) step();
        key_in = 4'b1111;
        wait_kd(3, 1'b0, "rr_kd3_low");
        drain("rr_drain");
        chk("rr_after", int'(dut.rr), 1);

        // Backpressure and overflow on key 0
        ev_ready = 1'b0;
        push(0, 0);
        press_short(0);
        repeat (4) step();
        chk("bp_valid1", int'(ev_valid), 1);
        chk("bp_key1", int'(ev_key), 0);
        chk("bp_long1", int'(ev_long), 0);
        push(0, 0);
        press_short(0);
        repeat (4) step();
        chk("bp_valid2", int'(ev_valid), 1);
        chk("bp_key2", int'(ev_key), 0);
        chk("bp_ovf_none", int'(ovf[0]), 0);
        chk("bp_pending", int'(dut.slot_v[0]), 1);
        press_short(0);
        repeat (4) step();
        chk("bp_ovf_set", int'(ovf[0]), 1);
        chk("bp_valid3", int'(ev_valid), 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", int'(ovf), 0);
        ev_ready = 1'b1;
        drain("bp_drain");
        repeat (4) step();
        chk("bp_idle", int'(ev_valid), 0);

        // Reset mid-press on key 3
        key_in[3] = 1'b0;
        wait_kd(3, 1'b1, "rm_kd_high");
        repeat (12) step();
        rst_n = 1'b0;
        step();
        step();
        chk("rm_ev_valid", int'(ev_valid), 0);
        chk("rm_key_down", int'(key_down), 0);
        chk("rm_ovf", int'(ovf), 0);
        chk("rm_rr", int'(dut.rr), 0);
        rst_n = 1'b1;
        repeat (60) step();
        chk("rm_held_no_kd", int'(key_down[3]), 0);
        key_in[3] = 1'b1;
        repeat (20) step();
        chk("rm_released_kd", int'(key_down[3]), 0);
        push(3, 0);
        press_short(3);
        drain("rm_drain");

        repeat (10) step();
        chk("final_queue", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
